// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_STALL = 2'd2,
    MD_STALL = 2'd3
  } ctrl_state_t;

  localparam int unsigned MULT_CYCLES_D = 5;
  localparam int unsigned DIV_CYCLES_D  = 10;

  // Register 0 is hard-wired, so a match against it is never a dependency.
  function automatic logic reg_hit(logic [4:0] src, logic en, logic [4:0] dst);
    return en && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide latency timer: loads on an MD start, counts down to zero.
module md_busy_timer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int unsigned W = $clog2(DIV_CYCLES + 1);
  localparam logic [W-1:0] MULT_LD = W'(MULT_CYCLES);
  localparam logic [W-1:0] DIV_LD  = W'(DIV_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = is_div_i ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch early-operand and MD-busy
// stalls, optional IF/ID flush, debug state and stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_D,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_D,
  parameter int unsigned DELAY_SLOT  = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRs,
  input  logic        ID_UseRt,
  input  logic        ID_UseRsEarly,
  input  logic        ID_UseRtEarly,
  input  logic        ID_IsMD,
  input  logic        ID_BranchTaken,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemToReg,
  input  logic [4:0]  MEM_WriteReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemToReg,
  input  logic        EX_MDStart,
  input  logic        EX_MDIsDiv,
  output logic        PC_En,
  output logic        IFID_En,
  output logic        ResetIDIF,
  output logic        IDEX_Bubble,
  output logic        MD_Busy,
  output logic [1:0]  CtrlState,
  output logic [31:0] StallCycles
);

  localparam logic FLUSH_EN = (DELAY_SLOT == 0);

  ctrl_state_t state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        md_busy;
  logic        hz_lu, hz_br, hz_md, stall;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .start_i  (EX_MDStart),
    .is_div_i (EX_MDIsDiv),
    .busy_o   (md_busy)
  );

  always_comb begin
    hz_lu = EX_RegWrite && EX_MemToReg &&
            (reg_hit(ID_Rs, ID_UseRs, EX_WriteReg) ||
             reg_hit(ID_Rt, ID_UseRt, EX_WriteReg));
    hz_br = (EX_RegWrite &&
             (reg_hit(ID_Rs, ID_UseRsEarly, EX_WriteReg) ||
              reg_hit(ID_Rt, ID_UseRtEarly, EX_WriteReg))) ||
            (MEM_RegWrite && MEM_MemToReg &&
             (reg_hit(ID_Rs, ID_UseRsEarly, MEM_WriteReg) ||
              reg_hit(ID_Rt, ID_UseRtEarly, MEM_WriteReg)));
    hz_md = ID_IsMD && (md_busy || EX_MDStart);
    stall = hz_lu || hz_br || hz_md;
  end

  always_comb begin
    state_d     = RUN;
    stall_cnt_d = stall_cnt_q;
    if (hz_md) begin
      state_d = MD_STALL;
    end else if (hz_lu) begin
      state_d = LU_STALL;
    end else if (hz_br) begin
      state_d = BR_STALL;
    end
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces the pipeline-frozen/flushed view without waiting for an edge.
  assign PC_En       = Reset_n && !stall;
  assign IFID_En     = Reset_n && !stall;
  assign IDEX_Bubble = !Reset_n || stall;
  assign ResetIDIF   = !Reset_n || (FLUSH_EN && ID_BranchTaken && !stall);
  assign MD_Busy     = md_busy;
  assign CtrlState   = state_q;
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a time-based reference model; two instances cover both DELAY_SLOT values.
module tb_hazard_ctrl;

  logic        Clk, Reset_n;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
  logic        ID_UseRs, ID_UseRt, ID_UseRsEarly, ID_UseRtEarly, ID_IsMD, ID_BranchTaken;
  logic        EX_RegWrite, EX_MemToReg, MEM_RegWrite, MEM_MemToReg, EX_MDStart, EX_MDIsDiv;

  logic        pc0, ifid0, rst0, bub0, busy0;
  logic [1:0]  st0;
  logic [31:0] cnt0;
  logic        pc1, ifid1, rst1, bub1, busy1;
  logic [1:0]  st1;
  logic [31:0] cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state: absolute cycle numbers rather than a countdown.
  int          cyc;
  int          md_end;
  logic [1:0]  m_state;
  logic [31:0] m_cnt;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .DELAY_SLOT(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_UseRsEarly(ID_UseRsEarly),
    .ID_UseRtEarly(ID_UseRtEarly), .ID_IsMD(ID_IsMD), .ID_BranchTaken(ID_BranchTaken),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
    .EX_MDStart(EX_MDStart), .EX_MDIsDiv(EX_MDIsDiv),
    .PC_En(pc0), .IFID_En(ifid0), .ResetIDIF(rst0), .IDEX_Bubble(bub0),
    .MD_Busy(busy0), .CtrlState(st0), .StallCycles(cnt0));

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .DELAY_SLOT(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt), .ID_UseRsEarly(ID_UseRsEarly),
    .ID_UseRtEarly(ID_UseRtEarly), .ID_IsMD(ID_IsMD), .ID_BranchTaken(ID_BranchTaken),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
    .EX_MDStart(EX_MDStart), .EX_MDIsDiv(EX_MDIsDiv),
    .PC_En(pc1), .IFID_En(ifid1), .ResetIDIF(rst1), .IDEX_Bubble(bub1),
    .MD_Busy(busy1), .CtrlState(st1), .StallCycles(cnt1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    ID_Rs = '0; ID_Rt = '0; ID_UseRs = 0; ID_UseRt = 0; ID_UseRsEarly = 0;
    ID_UseRtEarly = 0; ID_IsMD = 0; ID_BranchTaken = 0;
    EX_WriteReg = '0; EX_RegWrite = 0; EX_MemToReg = 0;
    MEM_WriteReg = '0; MEM_RegWrite = 0; MEM_MemToReg = 0;
    EX_MDStart = 0; EX_MDIsDiv = 0;
  endtask

  function automatic logic dep(logic [4:0] src, logic en, logic [4:0] dst);
    return en && src == dst && dst != 0;
  endfunction

  task automatic chk_reset_view();
    chk("rst_pc0", pc0, 0);    chk("rst_ifid0", ifid0, 0);
    chk("rst_flush0", rst0, 1); chk("rst_bub0", bub0, 1);
    chk("rst_busy0", busy0, 0); chk("rst_state0", st0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_pc1", pc1, 0);    chk("rst_flush1", rst1, 1);
    chk("rst_bub1", bub1, 1);  chk("rst_busy1", busy1, 0);
    chk("rst_cnt1", cnt1, 0);
  endtask

  task automatic model_reset();
    md_end = -1; m_state = 0; m_cnt = 0;
  endtask

  // One clock cycle: inputs already driven; check combinational and registered
  // outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    logic lu, br, md, busy, stl;
    #2;
    lu   = EX_RegWrite && EX_MemToReg &&
           (dep(ID_Rs, ID_UseRs, EX_WriteReg) || dep(ID_Rt, ID_UseRt, EX_WriteReg));
    br   = (EX_RegWrite && (dep(ID_Rs, ID_UseRsEarly, EX_WriteReg) ||
                            dep(ID_Rt, ID_UseRtEarly, EX_WriteReg))) ||
           (MEM_RegWrite && MEM_MemToReg && (dep(ID_Rs, ID_UseRsEarly, MEM_WriteReg) ||
                                             dep(ID_Rt, ID_UseRtEarly, MEM_WriteReg)));
    busy = (cyc <= md_end);
    md   = ID_IsMD && (busy || EX_MDStart);
    stl  = lu || br || md;
    chk("pc_en", pc0, !stl);       chk("ifid_en", ifid0, !stl);
    chk("bubble", bub0, stl);      chk("md_busy", busy0, busy);
    chk("flush_ds0", rst0, ID_BranchTaken && !stl);
    chk("state", st0, m_state);    chk("stall_cnt", cnt0, m_cnt);
    chk("pc_en_ds1", pc1, !stl);   chk("bubble_ds1", bub1, stl);
    chk("flush_ds1", rst1, 0);     chk("md_busy_ds1", busy1, busy);
    chk("state_ds1", st1, m_state); chk("cnt_ds1", cnt1, m_cnt);
    @(posedge Clk);
    #1;
    m_state = md ? 2'd3 : lu ? 2'd1 : br ? 2'd2 : 2'd0;
    if (stl) m_cnt = m_cnt + 1;
    if (EX_MDStart) md_end = cyc + (EX_MDIsDiv ? 10 : 5);
    cyc++;
  endtask

  // Assert reset between edges, check the immediate view, release after an edge.
  task automatic mid_reset();
    #2;
    Reset_n = 0;
    #1;
    chk_reset_view();
    @(posedge Clk);
    #1;
    Reset_n = 1;
    model_reset();
    cyc++;
  endtask

  int stall_n;

  initial begin
    cyc = 0;
    model_reset();
    idle();
    Reset_n = 0;
    #3;
    chk_reset_view();
    @(posedge Clk);
    #1;
    Reset_n = 1;
    cyc++;

    // Load-use: lw r1 in EX, addu consuming r1 in ID.
    EX_RegWrite = 1; EX_MemToReg = 1; EX_WriteReg = 5'd1; ID_UseRs = 1; ID_Rs = 5'd1;
    cycle();
    chk("lu_state", st0, 2'd1); chk("lu_cnt", cnt0, 1);
    idle(); MEM_RegWrite = 1; MEM_MemToReg = 1; MEM_WriteReg = 5'd1; ID_UseRs = 1; ID_Rs = 5'd1;
    cycle();
    chk("lu_once", cnt0, 1);

    // Branch after ALU write to r2: one stall.
    idle(); EX_RegWrite = 1; EX_WriteReg = 5'd2; ID_UseRsEarly = 1; ID_Rs = 5'd2;
    cycle();
    idle(); MEM_RegWrite = 1; MEM_WriteReg = 5'd2; ID_UseRsEarly = 1; ID_Rs = 5'd2;
    cycle();
    chk("br_alu_cnt", cnt0, 2);

    // Branch after load to r2 via Rt: two stalls.
    idle(); EX_RegWrite = 1; EX_MemToReg = 1; EX_WriteReg = 5'd2; ID_UseRtEarly = 1; ID_Rt = 5'd2;
    cycle();
    chk("br_ld_state", st0, 2'd2);
    idle(); MEM_RegWrite = 1; MEM_MemToReg = 1; MEM_WriteReg = 5'd2; ID_UseRtEarly = 1; ID_Rt = 5'd2;
    cycle();
    idle(); ID_UseRtEarly = 1; ID_Rt = 5'd2;
    cycle();
    chk("br_ld_cnt", cnt0, 4);

    // Register 0 never forms a hazard.
    idle(); EX_RegWrite = 1; EX_MemToReg = 1; EX_WriteReg = 5'd0; ID_UseRs = 1; ID_UseRsEarly = 1;
    cycle();
    chk("r0_cnt", cnt0, 4);

    // mult then div started with an MD op already in ID: stall N+1 cycles.
    for (int k = 0; k < 2; k++) begin
      int unsigned n;
      n = (k == 0) ? 5 : 10;
      idle(); EX_MDStart = 1; EX_MDIsDiv = (k == 1); ID_IsMD = 1;
      stall_n = 0;
      cycle();
      if (m_state == 2'd3) stall_n++;
      EX_MDStart = 0; EX_MDIsDiv = 0;
      for (int unsigned i = 0; i < n + 2; i++) begin
        cycle();
        if (m_state == 2'd3) stall_n++;
      end
      chk(k == 0 ? "mult_stalls" : "div_stalls", stall_n, n + 1);
    end

    // Taken branch: flush without hazard, suppressed while stalled.
    idle(); ID_BranchTaken = 1;
    cycle();
    EX_RegWrite = 1; EX_MemToReg = 1; EX_WriteReg = 5'd3; ID_UseRsEarly = 1; ID_Rs = 5'd3;
    cycle();
    idle(); ID_BranchTaken = 1; ID_UseRsEarly = 1; ID_Rs = 5'd3;
    MEM_RegWrite = 1; MEM_MemToReg = 1; MEM_WriteReg = 5'd3;
    cycle();
    MEM_RegWrite = 0;
    #2;
    chk("flush_after_stall", rst0, 1);
    cycle();

    // Reset in the middle of a divide, then mflo proceeds freely.
    idle(); EX_MDStart = 1; EX_MDIsDiv = 1;
    cycle();
    idle();
    cycle(); cycle();
    mid_reset();
    ID_IsMD = 1;
    cycle();
    chk("post_rst_mflo", st0, 2'd0);

    // Random traffic with a small register window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
      ID_UseRs = 1'($urandom); ID_UseRt = 1'($urandom);
      ID_UseRsEarly = ($urandom_range(0, 3) == 0); ID_UseRtEarly = ($urandom_range(0, 3) == 0);
      ID_IsMD = ($urandom_range(0, 2) == 0); ID_BranchTaken = ($urandom_range(0, 3) == 0);
      EX_WriteReg = 5'($urandom_range(0, 3)); EX_RegWrite = 1'($urandom); EX_MemToReg = 1'($urandom);
      MEM_WriteReg = 5'($urandom_range(0, 3)); MEM_RegWrite = 1'($urandom); MEM_MemToReg = 1'($urandom);
      EX_MDStart = ($urandom_range(0, 9) == 0); EX_MDIsDiv = 1'($urandom);
      if ($urandom_range(0, 99) == 0) mid_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
